div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Iterative radix-2 restoring divider for DIV/DIVU, instantiated next to the EX-stage ALU.
//  Generates the div_stop stall request that the hazard unit consumes to hold EX (stallE=01).
//  Returns quotient/remainder for the HI/LO write path.
//  Stall is requested in the same cycle the divide is first seen, so EX never advances early.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count = WIDTH
// PORTS
//  clk          in   1      core clock, all state on rising edge
//  reset        in   1      asynchronous, active-high; forces IDLE and clears all outputs
//  div_req      in   1      EX holds a valid DIV/DIVU (es_valid & div op); held while div_stop=1
//  div_signed   in   1      1=DIV, 0=DIVU; sampled with operands
//  div_src1     in   WIDTH  dividend (rs), stable while div_req=1
//  div_src2     in   WIDTH  divisor (rt), stable while div_req=1
//  es_go        in   1      EX instruction leaves EX this cycle (ready_go & ms_allowin)
//  div_cancel   in   1      pipeline flush (exception/eret); aborts any operation
//  div_stop     out  1      stall request to hazard unit
//  div_done     out  1      result valid (DONE state)
//  div_quot     out  WIDTH  quotient, to LO
//  div_rem      out  WIDTH  remainder, to HI
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, div_quot=0, div_rem=0; div_stop=0, div_done=0.
//  - States IDLE, CALC, DONE.
//    IDLE: if div_req & !div_cancel, latch |src1|, |src2|, sign flags, and div_signed.
//      Clear the partial remainder, set cnt=0, go to CALC.
//    CALC: one restoring step per cycle. Shift {rem,dvd} left by 1.
//      If rem>=divisor: subtract, and shift a 1 into quotient; else shift in 0. cnt++.
//      After the step with cnt==WIDTH-1, go to DONE.
//    DONE: div_quot/div_rem hold the sign-corrected result; go to IDLE on es_go, else stay.
//  - div_stop = !div_cancel & ((IDLE & div_req) | CALC), combinational.
//    div_stop is 0 in DONE, letting EX advance.
//  - div_done = (state==DONE), registered.
//  - Latency: req seen in IDLE at cycle T -> CALC T+1..T+WIDTH -> DONE at T+WIDTH+1.
//    div_stop is high for WIDTH+1 cycles.
//  - Sign fix (div_signed=1 only):
//    quot negated if src1[MSB]^src2[MSB]; rem negated if src1[MSB]. Magnitudes use two's complement.
//  - 0x80000000/-1 (signed): magnitudes 0x80000000/1, negated -> quot=0x80000000, rem=0.
//  - Divide by zero (deterministic, no trap): magnitude quot=all ones, rem=|src1|.
//    Sign fix is then applied as above.
//  - div_cancel: in any state, go to IDLE next cycle and force div_stop=0 in the same cycle.
//    The latched result is not updated; div_done=0 next cycle.
//  - div_req falling while in CALC without div_cancel is a protocol violation; the block completes anyway.
//  - DONE with es_go=0 (downstream stall): hold DONE and outputs; no restart on the still-high div_req.
//  - DONE->IDLE then div_req=1 (back-to-back divide): new operation starts in that IDLE cycle.
//  - div_quot/div_rem keep the last result until the next CALC->DONE transition.
//    Intermediate CALC values never appear on the outputs.
// TESTING
//  1. DIVU 100/7, es_go=1 in DONE: div_stop high 33 cycles, then done=1, quot=14, rem=2.
//  2. DIV -7/2 -> quot=0xFFFFFFFD, rem=0xFFFFFFFF; DIV 7/-2 -> quot=0xFFFFFFFD, rem=1.
//  3. DIV 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0.
//     DIVU 5/0 -> quot=0xFFFFFFFF, rem=5.
//  4. Assert div_cancel at CALC cycle 10 -> div_stop=0 that cycle, IDLE next cycle.
//     Prior quot/rem are unchanged; a new req then completes normally.
//  5. Hold es_go=0 for 3 cycles in DONE -> done stays 1, no restart.
//     Then es_go=1 with a new req next cycle -> second divide stalls for 33 cycles.
//  6. Assert reset mid-CALC (async, off-edge) -> immediate IDLE, div_stop=0, quot=rem=0.

Source files
------------

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider (DIV/DIVU) beside the EX-stage ALU.
// Raises div_stop from the first cycle a divide is seen until the result is ready.
// Quotient/remainder are registered only on the final step, so they hold the last result.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_req,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_src1,
    input  logic [WIDTH-1:0] div_src2,
    input  logic             es_go,
    input  logic             div_cancel,
    output logic             div_stop,
    output logic             div_done,
    output logic [WIDTH-1:0] div_quot,
    output logic [WIDTH-1:0] div_rem
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [WIDTH-1:0] rem_r;      // partial remainder
    logic [WIDTH-1:0] quo_r;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_r;      // divisor magnitude
    logic             neg_q_r;
    logic             neg_r_r;

    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;
    logic [WIDTH-1:0] quot_fix_s;
    logic [WIDTH-1:0] rem_fix_s;
    logic             start_s;
    logic             last_s;

    // Two's complement negate when neg is set; also yields magnitudes of signed operands.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] one;
        one      = {{(WIDTH-1){1'b0}}, 1'b1};
        cond_neg = neg ? (~v + one) : v;
    endfunction

    assign start_s = (state_r == ST_IDLE) & div_req & ~div_cancel;
    assign last_s  = (state_r == ST_CALC) & (cnt_r == CNT_LAST) & ~div_cancel;

    // Stall EX from the very first cycle the divide is visible; cancel and reset drop it at once.
    assign div_stop = ~reset & ~div_cancel &
                      (((state_r == ST_IDLE) & div_req) | (state_r == ST_CALC));

    // One restoring step: shift {rem,dvd} left, subtract divisor when it fits.
    // A zero divisor always "fits", giving all-ones quotient and rem = |dividend|.
    always_comb begin
        rem_sh_s   = {rem_r, quo_r[WIDTH-1]};
        rem_step_s = rem_sh_s[WIDTH-1:0];
        quo_step_s = {quo_r[WIDTH-2:0], 1'b0};
        if (rem_sh_s >= {1'b0, dvs_r}) begin
            rem_step_s = rem_sh_s[WIDTH-1:0] - dvs_r;
            quo_step_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_step_s = rem_sh_s[WIDTH-1:0];
            quo_step_s = {quo_r[WIDTH-2:0], 1'b0};
        end
        quot_fix_s = cond_neg(quo_step_s, neg_q_r);
        rem_fix_s  = cond_neg(rem_step_s, neg_r_r);
    end

    // Next-state selection; a cancel returns to IDLE from anywhere.
    always_comb begin
        state_nxt_s = state_r;
        if (div_cancel) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (div_req) state_nxt_s = ST_CALC;
                    else         state_nxt_s = ST_IDLE;
                end
                ST_CALC: begin
                    if (cnt_r == CNT_LAST) state_nxt_s = ST_DONE;
                    else                   state_nxt_s = ST_CALC;
                end
                ST_DONE: begin
                    if (es_go) state_nxt_s = ST_IDLE;
                    else       state_nxt_s = ST_DONE;
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register and registered done flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            div_done <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            div_done <= (state_nxt_s == ST_DONE);
        end
    end

    // Iteration datapath: load magnitudes on start, step once per CALC cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r   <= {CW{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            dvs_r   <= {WIDTH{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (start_s) begin
            cnt_r   <= {CW{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= cond_neg(div_src1, div_signed & div_src1[WIDTH-1]);
            dvs_r   <= cond_neg(div_src2, div_signed & div_src2[WIDTH-1]);
            neg_q_r <= div_signed & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
            neg_r_r <= div_signed & div_src1[WIDTH-1];
        end else if ((state_r == ST_CALC) && !div_cancel) begin
            cnt_r <= cnt_r + CNT_ONE;
            rem_r <= rem_step_s;
            quo_r <= quo_step_s;
        end else begin
            cnt_r <= cnt_r;
            rem_r <= rem_r;
            quo_r <= quo_r;
        end
    end

    // Result registers: only the final step updates them, with sign correction applied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_quot <= {WIDTH{1'b0}};
            div_rem  <= {WIDTH{1'b0}};
        end else if (last_s) begin
            div_quot <= quot_fix_s;
            div_rem  <= rem_fix_s;
        end else begin
            div_quot <= div_quot;
            div_rem  <= div_rem;
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed bench for div_iter; expected results go into a scoreboard queue
// and a monitor compares them whenever div_done rises.
module tb_div_iter;

    logic        clk;
    logic        reset;
    logic        div_req;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        es_go;
    logic        div_cancel;
    logic        div_stop;
    logic        div_done;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] last_q;
    logic [31:0] last_r;
    logic        done_prev;

    div_iter #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .div_req    (div_req),
        .div_signed (div_signed),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .es_go      (es_go),
        .div_cancel (div_cancel),
        .div_stop   (div_stop),
        .div_done   (div_done),
        .div_quot   (div_quot),
        .div_rem    (div_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising div_done must match the oldest expected result.
    initial begin
        logic [63:0] e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (div_done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {div_quot, div_rem}, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {div_quot, div_rem}, e);
                end
            end
            done_prev = div_done;
        end
    end

    // Issue one divide, measure the stall length, hold DONE for go_delay cycles,
    // then raise es_go at the last DONE negedge (next call starts back-to-back).
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input int go_delay);
        int n;
        bit hold_ok;
        exp_q.push_back({eq, er});
        @(posedge clk); #1;
        div_req    = 1'b1;
        div_signed = sgn;
        div_src1   = a;
        div_src2   = b;
        es_go      = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!div_stop) break;
            n++;
        end
        check("stop_cycles", 64'(n), 64'd33);
        check("done_high", {63'd0, div_done}, 64'd1);
        hold_ok = 1'b1;
        for (int i = 0; i < go_delay; i++) begin
            @(negedge clk);
            if (!div_done || div_stop) hold_ok = 1'b0;
        end
        if (go_delay > 0) check("done_hold", {63'd0, hold_ok}, 64'd1);
        last_q = eq;
        last_r = er;
        es_go  = 1'b1;
    endtask

    initial begin
        int n;
        bit ok;
        reset      = 1'b1;
        div_req    = 1'b0;
        div_signed = 1'b0;
        div_src1   = 32'd0;
        div_src2   = 32'd0;
        es_go      = 1'b0;
        div_cancel = 1'b0;
        last_q     = 32'd0;
        last_r     = 32'd0;

        // Reset state
        @(negedge clk);
        check("rst_stop", {63'd0, div_stop}, 64'd0);
        check("rst_done", {63'd0, div_done}, 64'd0);
        check("rst_qr", {div_quot, div_rem}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Main function and signed / boundary cases
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
        run_div(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0);
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB, 0);
        run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'hF, 0);

        // Cancel mid-CALC: stop drops immediately, results untouched
        @(posedge clk); #1;
        div_req    = 1'b1;
        div_signed = 1'b0;
        div_src1   = 32'd50;
        div_src2   = 32'd3;
        es_go      = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (!div_stop) ok = 1'b0;
        end
        check("cancel_pre_stop", {63'd0, ok}, 64'd1);
        div_cancel = 1'b1;
        #1;
        check("cancel_stop", {63'd0, div_stop}, 64'd0);
        @(posedge clk); #1;
        div_cancel = 1'b0;
        div_req    = 1'b0;
        @(negedge clk);
        check("cancel_idle_stop", {63'd0, div_stop}, 64'd0);
        check("cancel_done", {63'd0, div_done}, 64'd0);
        check("cancel_keep_qr", {div_quot, div_rem}, {last_q, last_r});
        run_div(1'b0, 32'd50, 32'd3, 32'd16, 32'd2, 0);

        // DONE held under downstream stall, then back-to-back divide
        run_div(1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 3);
        run_div(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 0);

        // Async reset in the middle of CALC, away from the clock edge
        @(posedge clk); #1;
        div_req    = 1'b1;
        div_signed = 1'b0;
        div_src1   = 32'd123;
        div_src2   = 32'd4;
        es_go      = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_stop", {63'd0, div_stop}, 64'd0);
        check("arst_done", {63'd0, div_done}, 64'd0);
        check("arst_qr", {div_quot, div_rem}, 64'd0);
        @(posedge clk); #1;
        reset   = 1'b0;
        div_req = 1'b0;
        @(negedge clk);
        check("post_arst_stop", {63'd0, div_stop}, 64'd0);
        check("post_arst_done", {63'd0, div_done}, 64'd0);

        n = exp_q.size();
        check("scoreboard_empty", 64'(n), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
